store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/utils_pkg.sv | 41 ++++
 rtl/sb_fifo.sv | 39 +++
 rtl/store_buffer.sv | 110 +++++++++++
 tb/tb_store_buffer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/utils_pkg.sv
// utils_pkg: core data bus channel types, store-buffer entry and drain FSM states
package utils_pkg;
   localparam int CB_AW        = 32;
   localparam int CB_DW        = 32;
   localparam int SB_DEPTH_DEF = 4;

   typedef enum logic [1:0] {CB_BYTE, CB_HALF, CB_WORD} cb_size_t;
   typedef enum logic [1:0] {CB_OKAY, CB_EXOKAY, CB_SLVERR, CB_DECERR} cb_resp_t;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} sb_state_t;

   typedef struct packed {
      logic [CB_AW-1:0]   addr;
      logic [CB_DW-1:0]   data;
      logic [CB_DW/8-1:0] strb;
   } s_sb_entry_t;

   typedef struct packed {
      logic [CB_AW-1:0]   wr_addr;
      logic               wr_addr_valid;
      cb_size_t           wr_size;
      logic [CB_DW-1:0]   wr_data;
      logic [CB_DW/8-1:0] wr_strobe;
      logic               wr_data_valid;
      logic               wr_resp_ready;
      logic [CB_AW-1:0]   rd_addr;
      logic               rd_addr_valid;
      cb_size_t           rd_size;
      logic               rd_ready;
   } s_cb_mosi_t;

   typedef struct packed {
      logic               wr_addr_ready;
      logic               wr_data_ready;
      logic               wr_resp_valid;
      cb_resp_t           wr_resp_error;
      logic               rd_addr_ready;
      logic [CB_DW-1:0]   rd_data;
      logic               rd_valid;
      cb_resp_t           rd_resp;
   } s_cb_miso_t;
endpackage

// File: rtl/sb_fifo.sv
// sb_fifo: register FIFO of posted write entries with occupancy count
module sb_fifo
   import utils_pkg::*;
#(
   parameter  int DEPTH = SB_DEPTH_DEF,
   localparam int PW    = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  logic        pop,
   input  s_sb_entry_t din,
   output s_sb_entry_t head,
   output logic [PW:0] count,
   output logic        full,
   output logic        empty
);
   s_sb_entry_t   mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;

   // pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         count <= count + (PW+1)'(push) - (PW+1)'(pop);
      end

   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= din;

   assign head  = mem[rd_ptr];
   assign full  = (count == (PW+1)'(DEPTH));
   assign empty = (count == '0);
endmodule

// File: rtl/store_buffer.sv
// store_buffer: posts LSU writes into a FIFO and drains them in order to memory,
// holding reads back while any write is buffered so loads see the newest data.
module store_buffer
   import utils_pkg::*;
#(
   parameter int SB_DEPTH     = SB_DEPTH_DEF,
   parameter bit SB_RAW_STALL = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  s_cb_mosi_t lsu_cb_mosi_i,
   output s_cb_miso_t lsu_cb_miso_o,
   output s_cb_mosi_t mem_cb_mosi_o,
   input  s_cb_miso_t mem_cb_miso_i,
   output logic       sb_empty_o,
   output logic       sb_err_o
);
   localparam int PW = $clog2(SB_DEPTH);

   sb_state_t        state, state_nxt;
   logic             hold_vld, resp_pend, aw_done, w_done;
   logic [CB_AW-1:0] hold_addr;
   logic             lsu_aw_hs, push, pop, aw_hs, w_hs, full, empty, rd_go;
   logic [PW:0]      count;
   s_sb_entry_t      din, head;
   logic             unused_ok;

   assign lsu_aw_hs = lsu_cb_mosi_i.wr_addr_valid & ~full & ~hold_vld;
   assign push      = lsu_cb_mosi_i.wr_data_valid & hold_vld;
   assign aw_hs     = mem_cb_mosi_o.wr_addr_valid & mem_cb_miso_i.wr_addr_ready;
   assign w_hs      = mem_cb_mosi_o.wr_data_valid & mem_cb_miso_i.wr_data_ready;
   assign pop       = (state == WAIT_RESP) & mem_cb_miso_i.wr_resp_valid;
   assign din       = '{addr: hold_addr, data: lsu_cb_mosi_i.wr_data, strb: lsu_cb_mosi_i.wr_strobe};
   assign unused_ok = ^{lsu_cb_mosi_i.wr_size, lsu_cb_mosi_i.wr_resp_ready};

   sb_fifo #(.DEPTH(SB_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (din),
      .head  (head),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         hold_vld  <= 1'b0;
         resp_pend <= 1'b0;
      end else begin
         hold_vld  <= lsu_aw_hs | (hold_vld & ~push);
         resp_pend <= push;
      end

   always_ff @(posedge clk)
      if (lsu_aw_hs) hold_addr <= lsu_cb_mosi_i.wr_addr;

   // handshake flags only live while in ISSUE and are cleared on exit
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state   <= IDLE;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else begin
         state   <= state_nxt;
         aw_done <= (state_nxt == ISSUE) & (aw_done | aw_hs);
         w_done  <= (state_nxt == ISSUE) & (w_done | w_hs);
      end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      state_nxt = empty ? IDLE : ISSUE;
         ISSUE:     state_nxt = ((aw_done | aw_hs) & (w_done | w_hs)) ? WAIT_RESP : ISSUE;
         WAIT_RESP: state_nxt = mem_cb_miso_i.wr_resp_valid ? IDLE : WAIT_RESP;
         default:   state_nxt = IDLE;
      endcase
   end

   // a write that arrives together with a read takes priority over it
   assign sb_empty_o = (count == '0) & ~hold_vld & (state == IDLE);
   assign rd_go      = !SB_RAW_STALL || (sb_empty_o && !lsu_cb_mosi_i.wr_addr_valid);
   assign sb_err_o   = pop & (mem_cb_miso_i.wr_resp_error != CB_OKAY);

   always_comb begin
      mem_cb_mosi_o               = '0;
      mem_cb_mosi_o.wr_addr       = head.addr;
      mem_cb_mosi_o.wr_data       = head.data;
      mem_cb_mosi_o.wr_strobe     = head.strb;
      mem_cb_mosi_o.wr_size       = CB_WORD;
      mem_cb_mosi_o.wr_addr_valid = (state == ISSUE) & ~aw_done;
      mem_cb_mosi_o.wr_data_valid = (state == ISSUE) & ~w_done;
      mem_cb_mosi_o.wr_resp_ready = (state == WAIT_RESP);
      mem_cb_mosi_o.rd_addr       = lsu_cb_mosi_i.rd_addr;
      mem_cb_mosi_o.rd_size       = lsu_cb_mosi_i.rd_size;
      mem_cb_mosi_o.rd_addr_valid = lsu_cb_mosi_i.rd_addr_valid & rd_go;
      mem_cb_mosi_o.rd_ready      = lsu_cb_mosi_i.rd_ready;
      lsu_cb_miso_o               = '0;
      lsu_cb_miso_o.wr_addr_ready = ~full & ~hold_vld;
      lsu_cb_miso_o.wr_data_ready = hold_vld;
      lsu_cb_miso_o.wr_resp_valid = resp_pend;
      lsu_cb_miso_o.wr_resp_error = CB_OKAY;
      lsu_cb_miso_o.rd_addr_ready = mem_cb_miso_i.rd_addr_ready & rd_go;
      lsu_cb_miso_o.rd_data       = mem_cb_miso_i.rd_data;
      lsu_cb_miso_o.rd_valid      = mem_cb_miso_i.rd_valid;
      lsu_cb_miso_o.rd_resp       = mem_cb_miso_i.rd_resp;
   end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: random LSU and memory traffic checked against a transaction-level
// model of posted writes (ordered queue, outstanding count, word memory image).
module tb_store_buffer;
   import utils_pkg::*;

   localparam int DEPTH = 4;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  s;
   } wr_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   s_cb_mosi_t l_mosi, m_mosi;
   s_cb_miso_t l_miso, m_miso;
   logic       sb_empty, sb_err;
   int         errors = 0;
   int         checks = 0;

   wr_t         exp_q[$];
   logic [31:0] ref_mem [16];
   logic [31:0] mem_arr [16];
   int          outst;
   logic        aw_got, w_got, rsp_pend, rsp_vld, rd_pend, prev_push, aw_blk, resp_blk;
   logic        lsu_aw, lsu_w, aw_hs, w_hs, rsp_hs, exp_rd;
   cb_resp_t    rsp_err;
   logic [31:0] rd_val, cap_addr, m_addr, m_data;
   logic [3:0]  m_strb;

   always #5 clk = ~clk;

   store_buffer #(.SB_DEPTH(DEPTH), .SB_RAW_STALL(1'b1)) dut (
      .clk           (clk),
      .rst           (rst),
      .lsu_cb_mosi_i (l_mosi),
      .lsu_cb_miso_o (l_miso),
      .mem_cb_mosi_o (m_mosi),
      .mem_cb_miso_i (m_miso),
      .sb_empty_o    (sb_empty),
      .sb_err_o      (sb_err)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
      for (int i = 0; i < 4; i++) if (s[i]) old[8*i+:8] = d[8*i+:8];
      return old;
   endfunction

   function automatic int idx(input logic [31:0] a);
      return int'(a[5:2]);
   endfunction

   // memory responder plus per-cycle model comparison, sampled 2ns after each falling edge
   initial begin
      for (int i = 0; i < 16; i++) begin
         ref_mem[i] = '0;
         mem_arr[i] = '0;
      end
      m_miso = '0;
      rsp_err = CB_OKAY;
      forever begin
         @(negedge clk);
         if (rsp_pend && !rsp_vld && !resp_blk && $urandom_range(0, 2) != 0) begin
            rsp_vld = 1'b1;
            rsp_err = ($urandom_range(0, 3) == 0) ? CB_SLVERR : CB_OKAY;
         end
         m_miso.wr_addr_ready = !aw_blk && $urandom_range(0, 1) == 1;
         m_miso.wr_data_ready = $urandom_range(0, 1) == 1;
         m_miso.wr_resp_valid = rsp_vld;
         m_miso.wr_resp_error = rsp_err;
         m_miso.rd_addr_ready = $urandom_range(0, 1) == 1;
         m_miso.rd_valid      = rd_pend;
         m_miso.rd_data       = rd_val;
         m_miso.rd_resp       = CB_OKAY;
         #2;
         if (!rst) begin
            exp_q.delete();
            outst = 0;
            {aw_got, w_got, rsp_pend, rsp_vld, rd_pend, prev_push} = '0;
         end else begin
            lsu_aw = l_mosi.wr_addr_valid & l_miso.wr_addr_ready;
            lsu_w  = l_mosi.wr_data_valid & l_miso.wr_data_ready;
            aw_hs  = m_mosi.wr_addr_valid & m_miso.wr_addr_ready;
            w_hs   = m_mosi.wr_data_valid & m_miso.wr_data_ready;
            rsp_hs = rsp_vld & m_mosi.wr_resp_ready;
            chk("empty", sb_empty, outst == 0);
            chk("aw_rdy", l_miso.wr_addr_ready, exp_q.size() < DEPTH && outst == exp_q.size());
            chk("w_rdy", l_miso.wr_data_ready, outst > exp_q.size());
            if (l_miso.wr_resp_valid || prev_push) begin
               chk("lsu_resp", l_miso.wr_resp_valid, prev_push);
               chk("lsu_resp_err", l_miso.wr_resp_error, CB_OKAY);
            end
            if (sb_err || rsp_hs) chk("sb_err", sb_err, rsp_hs && rsp_err != CB_OKAY);
            exp_rd = l_mosi.rd_addr_valid && outst == 0 && !l_mosi.wr_addr_valid;
            if (exp_rd || m_mosi.rd_addr_valid) chk("rd_gate", m_mosi.rd_addr_valid, exp_rd);
            if (aw_hs) begin
               chk("aw_once", aw_got, 1'b0);
               chk("aw_size", m_mosi.wr_size, CB_WORD);
               chk("aw_q", exp_q.size() != 0, 1'b1);
               if (exp_q.size() != 0) chk("aw_addr", m_mosi.wr_addr, exp_q[0].a);
               aw_got = 1'b1;
               m_addr = m_mosi.wr_addr;
            end
            if (w_hs) begin
               chk("w_once", w_got, 1'b0);
               chk("w_q", exp_q.size() != 0, 1'b1);
               if (exp_q.size() != 0) begin
                  chk("w_data", m_mosi.wr_data, exp_q[0].d);
                  chk("w_strb", m_mosi.wr_strobe, exp_q[0].s);
               end
               w_got  = 1'b1;
               m_data = m_mosi.wr_data;
               m_strb = m_mosi.wr_strobe;
            end
            if (aw_got && w_got && !rsp_pend) begin
               rsp_pend = 1'b1;
               mem_arr[idx(m_addr)] = merge(mem_arr[idx(m_addr)], m_data, m_strb);
            end
            if (rsp_hs) begin
               if (exp_q.size() != 0) void'(exp_q.pop_front());
               outst--;
               {aw_got, w_got, rsp_pend, rsp_vld} = '0;
            end
            if (rd_pend && m_mosi.rd_ready) rd_pend = 1'b0;
            if (m_mosi.rd_addr_valid && m_miso.rd_addr_ready) begin
               rd_pend = 1'b1;
               rd_val  = mem_arr[idx(m_mosi.rd_addr)];
            end
            prev_push = lsu_w;
            if (lsu_aw) begin
               outst++;
               cap_addr = l_mosi.wr_addr;
            end
            if (lsu_w) begin
               exp_q.push_back('{cap_addr, l_mosi.wr_data, l_mosi.wr_strobe});
               ref_mem[idx(cap_addr)] = merge(ref_mem[idx(cap_addr)], l_mosi.wr_data, l_mosi.wr_strobe);
            end
         end
      end
   end

   task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      int n = 0;
      l_mosi.wr_addr = a;
      l_mosi.wr_addr_valid = 1'b1;
      #2;
      while (!l_miso.wr_addr_ready && n < 300) begin @(negedge clk); #2; n++; end
      chk("aw_tmo", n < 300, 1'b1);
      @(negedge clk);
      l_mosi.wr_addr_valid = 1'b0;
      l_mosi.wr_data = d;
      l_mosi.wr_strobe = s;
      l_mosi.wr_data_valid = 1'b1;
      n = 0;
      #2;
      while (!l_miso.wr_data_ready && n < 50) begin @(negedge clk); #2; n++; end
      chk("w_tmo", n < 50, 1'b1);
      @(negedge clk);
      l_mosi.wr_data_valid = 1'b0;
   endtask

   task automatic do_load(input logic [31:0] a);
      int n = 0;
      l_mosi.rd_addr = a;
      l_mosi.rd_addr_valid = 1'b1;
      #2;
      while (!l_miso.rd_addr_ready && n < 300) begin @(negedge clk); #2; n++; end
      chk("rd_tmo", n < 300, 1'b1);
      @(negedge clk);
      l_mosi.rd_addr_valid = 1'b0;
      n = 0;
      #2;
      while (!l_miso.rd_valid && n < 50) begin @(negedge clk); #2; n++; end
      chk("rd_vld_tmo", n < 50, 1'b1);
      chk("rd_data", l_miso.rd_data, ref_mem[idx(a)]);
      @(negedge clk);
   endtask

   task automatic wait_empty();
      int n = 0;
      #2;
      while (!sb_empty && n < 500) begin @(negedge clk); #2; n++; end
      chk("drain_tmo", n < 500, 1'b1);
      @(negedge clk);
   endtask

   initial begin
      l_mosi = '0;
      l_mosi.rd_ready = 1'b1;
      aw_blk = 1'b0;
      resp_blk = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      chk("rst_empty", sb_empty, 1'b1);
      chk("rst_aw_rdy", l_miso.wr_addr_ready, 1'b1);
      chk("rst_mem_vld", {m_mosi.wr_addr_valid, m_mosi.wr_data_valid}, 2'b00);
      chk("rst_err", sb_err, 1'b0);
      chk("rst_resp", l_miso.wr_resp_valid, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      do_store(32'h100, 32'hDEADBEEF, 4'hF);
      wait_empty();
      chk("single_mem", mem_arr[idx(32'h100)], 32'hDEADBEEF);
      do_store(32'h200, 32'h1234_5678, 4'hF);
      do_load(32'h200);
      wait_empty();
      aw_blk = 1'b1;
      for (int i = 0; i < 4; i++) do_store(32'h110 + 32'(4*i), $urandom, 4'hF);
      repeat (3) begin
         #2;
         chk("fill_refuse", l_miso.wr_addr_ready, 1'b0);
         @(negedge clk);
      end
      aw_blk = 1'b0;
      do_store(32'h120, 32'hCAFE_F00D, 4'h5);
      wait_empty();
      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 9) < 7)
            do_store(32'h100 + 32'(4*$urandom_range(0, 15)), $urandom, 4'($urandom_range(1, 15)));
         else
            do_load(32'h100 + 32'(4*$urandom_range(0, 15)));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      wait_empty();
      l_mosi.rd_addr = 32'h104;
      l_mosi.rd_addr_valid = 1'b1;
      l_mosi.wr_addr = 32'h104;
      l_mosi.wr_addr_valid = 1'b1;
      #2;
      chk("same_wr_rdy", l_miso.wr_addr_ready, 1'b1);
      chk("same_rd_hold", m_mosi.rd_addr_valid, 1'b0);
      @(negedge clk);
      l_mosi.wr_addr_valid = 1'b0;
      l_mosi.wr_data = 32'hA5A5_0104;
      l_mosi.wr_strobe = 4'hF;
      l_mosi.wr_data_valid = 1'b1;
      @(negedge clk);
      l_mosi.wr_data_valid = 1'b0;
      do_load(32'h104);
      wait_empty();
      resp_blk = 1'b1;
      for (int i = 0; i < 3; i++) do_store(32'h180 + 32'(4*i), $urandom, 4'hF);
      repeat (6) @(negedge clk);
      rst = 1'b0;
      #2;
      chk("mid_rst_empty", sb_empty, 1'b1);
      chk("mid_rst_aw_rdy", l_miso.wr_addr_ready, 1'b1);
      chk("mid_rst_mem_vld", {m_mosi.wr_addr_valid, m_mosi.wr_data_valid, m_mosi.wr_resp_ready}, 3'b000);
      @(negedge clk);
      rst = 1'b1;
      resp_blk = 1'b0;
      repeat (5) begin
         #2;
         chk("post_rst_mem_vld", {m_mosi.wr_addr_valid, m_mosi.wr_data_valid}, 2'b00);
         chk("post_rst_resp", l_miso.wr_resp_valid, 1'b0);
         chk("post_rst_empty", sb_empty, 1'b1);
         @(negedge clk);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      repeat (40000) @(posedge clk);
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
